// File: rtl/seg7_pkg.sv
// Shared constants for the BCD step counter: seven-segment patterns
// (active-low, bit0 = a .. bit6 = g), BCD digit width and a helper that
// turns a decimal parameter into a two-digit BCD byte.
package seg7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal 0..99 to {tens, units} BCD; used on elaboration-time constants.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int value);
    return {BCD_W'(value / 10), BCD_W'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_step_counter_if.sv
// Board-side signal bundle of the BCD step counter. The master drives the
// divided wave and the two switches; the slave (the counter) drives the
// count, the wrap pulse and both seven-segment digits.
interface bcd_step_counter_if;
  import seg7_pkg::*;

  logic                 tick_in;
  logic                 pause_n;
  logic                 up_dn;
  logic [2*BCD_W-1:0]   count_bcd;
  logic                 wrap;
  logic [6:0]           HEX0;
  logic [6:0]           HEX1;

  modport master (
    output tick_in, pause_n, up_dn,
    input  count_bcd, wrap, HEX0, HEX1
  );

  modport slave (
    input  tick_in, pause_n, up_dn,
    output count_bcd, wrap, HEX0, HEX1
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// One BCD digit to an active-low seven-segment pattern. blank_i forces the
// digit dark; non-BCD codes also show dark rather than a random shape.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic             blank_i,
  output logic [6:0]       seg_o
);

  // Pattern lookup; every path assigns seg_o.
  always_comb begin
    // NOTE: seg_o gets a default first so no path through the block can
    // leave it unassigned and infer a latch.
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_step_counter.sv
// Two-digit BCD counter stepped by rising edges of a slow divided wave.
// The wave and the switches are treated as asynchronous data: each passes
// through its own synchronizer chain, the tick is edge-detected, and the
// registered step advances the count up or down between MIN_VAL and MAX_VAL.
module bcd_step_counter
  import seg7_pkg::*;
#(
  parameter int MIN_VAL     = 1,
  parameter int MAX_VAL     = 99,
  parameter int SYNC_STAGES = 2,
  parameter bit BLANK_TENS  = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  bcd_step_counter_if.slave  bus
);

  localparam logic [2*BCD_W-1:0] MIN_BCD = to_bcd2(MIN_VAL);
  localparam logic [2*BCD_W-1:0] MAX_BCD = to_bcd2(MAX_VAL);

  logic [SYNC_STAGES-1:0] tick_sync_q;
  logic [SYNC_STAGES-1:0] pause_sync_q;
  logic [SYNC_STAGES-1:0] dir_sync_q;
  logic                   sync_tick;
  logic                   sync_pause_n;
  logic                   sync_up_dn;
  logic                   tick_d_q;
  logic                   step_d;
  logic                   step_q;
  logic [2*BCD_W-1:0]     count_d;
  logic [2*BCD_W-1:0]     count_q;
  logic                   wrap_d;
  logic                   wrap_q;
  logic [BCD_W-1:0]       tens;
  logic [BCD_W-1:0]       units;
  logic                   in_range;

  assign sync_tick    = tick_sync_q[SYNC_STAGES-1];
  assign sync_pause_n = pause_sync_q[SYNC_STAGES-1];
  assign sync_up_dn   = dir_sync_q[SYNC_STAGES-1];

  // Synchronizer chains; pause chain clears to 0 so the counter stays held
  // until the key has actually been sampled high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_sync_q  <= '0;
      pause_sync_q <= '0;
      dir_sync_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      tick_sync_q  <= {tick_sync_q[SYNC_STAGES-2:0],  bus.tick_in};
      pause_sync_q <= {pause_sync_q[SYNC_STAGES-2:0], bus.pause_n};
      dir_sync_q   <= {dir_sync_q[SYNC_STAGES-2:0],   bus.up_dn};
    end
  end

  assign step_d = sync_tick & ~tick_d_q;

  // Rising-edge detect of the synchronized tick, registered as a one-cycle step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_d_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      tick_d_q <= sync_tick;
      step_q   <= step_d;
    end
  end

  assign tens     = count_q[2*BCD_W-1:BCD_W];
  assign units    = count_q[BCD_W-1:0];
  // Anything outside valid BCD or the configured range is treated as upset
  // and reloaded to the wrap target on the next step.
  assign in_range = (tens <= 4'd9) && (units <= 4'd9) &&
                    (count_q >= MIN_BCD) && (count_q <= MAX_BCD);

  // Next count and wrap flag for an unpaused step in the selected direction.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (step_q && sync_pause_n) begin
      if (sync_up_dn) begin
        if (!in_range || (count_q == MAX_BCD)) begin
          count_d = MIN_BCD;
          wrap_d  = 1'b1;
        end else if (units == 4'd9) begin
          count_d = {tens + 4'd1, 4'd0};
        end else begin
          count_d = {tens, units + 4'd1};
        end
      end else begin
        if (!in_range || (count_q == MIN_BCD)) begin
          count_d = MAX_BCD;
          wrap_d  = 1'b1;
        end else if (units == 4'd0) begin
          count_d = {tens - 4'd1, 4'd9};
        end else begin
          count_d = {tens, units - 4'd1};
        end
      end
    end
  end

  // Count and wrap registers; reset lands on MIN_VAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= MIN_BCD;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.wrap      = wrap_q;

  bcd_to_7seg u_units (
    .bcd_i   (units),
    .blank_i (1'b0),
    .seg_o   (bus.HEX0)
  );

  bcd_to_7seg u_tens (
    .bcd_i   (tens),
    .blank_i (BLANK_TENS && (tens == 4'd0)),
    .seg_o   (bus.HEX1)
  );

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter. A decimal reference model
// tracks the expected count from the ticks the bench itself generates.
module tb_bcd_step_counter;

  localparam int MIN_VAL = 1;
  localparam int MAX_VAL = 99;

  logic clk;
  logic reset_n;

  bcd_step_counter_if bus ();

  bcd_step_counter #(
    .MIN_VAL     (MIN_VAL),
    .MAX_VAL     (MAX_VAL),
    .SYNC_STAGES (2),
    .BLANK_TENS  (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int model_v   = MIN_VAL;
  int exp_wraps = 0;
  int wrap_cnt  = 0;

  // Counts clk cycles in which wrap is observed high.
  always @(negedge clk) begin
    if (bus.wrap === 1'b1) wrap_cnt++;
  end

  function automatic logic [7:0] dec_to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex1(input int v);
    return (v / 10 == 0) ? 7'b1111111 : seg_of(v / 10);
  endfunction

  // Reference: what one tick rising edge does to the decimal count.
  function automatic void model_tick(input bit up, input bit run);
    if (!run) return;
    if (up) begin
      if (model_v == MAX_VAL) begin
        model_v = MIN_VAL;
        exp_wraps++;
      end else begin
        model_v++;
      end
    end else begin
      if (model_v == MIN_VAL) begin
        model_v = MAX_VAL;
        exp_wraps++;
      end else begin
        model_v--;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.tick_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    model_v = MIN_VAL;
  endtask

  // Set switches, let them settle through the synchronizers, then issue one
  // tick pulse of random width and wait for the step to land.
  task automatic step_once(input bit up, input bit run);
    @(negedge clk);
    bus.up_dn   = up;
    bus.pause_n = run;
    repeat (3) @(negedge clk);
    bus.tick_in = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (5) @(negedge clk);
    model_tick(up, run);
  endtask

  task automatic test_reset();
    bus.tick_in = 1'b0;
    bus.pause_n = 1'b1;
    bus.up_dn   = 1'b1;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.count_bcd !== 8'h01) begin
      n_fail++; $display("FAIL reset_count: got %h want 01", bus.count_bcd);
    end
    n_checks++;
    if (bus.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_wrap: got %b want 0", bus.wrap);
    end
    n_checks++;
    if (bus.HEX0 !== 7'b1111001) begin
      n_fail++; $display("FAIL reset_hex0: got %b want 1111001", bus.HEX0);
    end
    n_checks++;
    if (bus.HEX1 !== 7'b1111111) begin
      n_fail++; $display("FAIL reset_hex1: got %b want 1111111", bus.HEX1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    model_v = MIN_VAL;
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.tick_in = 1'b1;          // first sampled high at the next edge (k)
    repeat (3) @(negedge clk);   // edges k, k+1, k+2 have passed
    n_checks++;
    if (bus.count_bcd !== 8'h01) begin
      n_fail++; $display("FAIL latency_early: got %h want 01", bus.count_bcd);
    end
    @(negedge clk);              // edge k+3 has passed
    n_checks++;
    if (bus.count_bcd !== 8'h02) begin
      n_fail++; $display("FAIL latency_k3: got %h want 02", bus.count_bcd);
    end
    repeat (2) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (5) @(negedge clk);
    model_tick(1'b1, 1'b1);
    step_once(1'b1, 1'b1);
    step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h04) begin
      n_fail++; $display("FAIL count_04: got %h want 04", bus.count_bcd);
    end
    n_checks++;
    if (bus.HEX0 !== 7'b0011001) begin
      n_fail++; $display("FAIL hex0_at_04: got %b want 0011001", bus.HEX0);
    end
    n_checks++;
    if (bus.HEX1 !== 7'b1111111) begin
      n_fail++; $display("FAIL hex1_blank_04: got %b want 1111111", bus.HEX1);
    end
  endtask

  task automatic test_tens_carry();
    int w0;
    repeat (5) step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h09) begin
      n_fail++; $display("FAIL count_09: got %h want 09", bus.count_bcd);
    end
    w0 = wrap_cnt;
    step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h10) begin
      n_fail++; $display("FAIL carry_10: got %h want 10", bus.count_bcd);
    end
    n_checks++;
    if (bus.HEX1 !== 7'b1111001) begin
      n_fail++; $display("FAIL carry_hex1: got %b want 1111001", bus.HEX1);
    end
    n_checks++;
    if (bus.HEX0 !== 7'b1000000) begin
      n_fail++; $display("FAIL carry_hex0: got %b want 1000000", bus.HEX0);
    end
    n_checks++;
    if (wrap_cnt - w0 !== 0) begin
      n_fail++; $display("FAIL carry_wrap: got %0d pulses want 0", wrap_cnt - w0);
    end
  endtask

  task automatic test_wrap();
    int w0;
    while (model_v != MAX_VAL) step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h99) begin
      n_fail++; $display("FAIL count_99: got %h want 99", bus.count_bcd);
    end
    w0 = wrap_cnt;
    step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h01) begin
      n_fail++; $display("FAIL wrap_up_count: got %h want 01", bus.count_bcd);
    end
    n_checks++;
    if (wrap_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL wrap_up_pulse: got %0d cycles want 1", wrap_cnt - w0);
    end
    w0 = wrap_cnt;
    step_once(1'b0, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h99) begin
      n_fail++; $display("FAIL wrap_dn_count: got %h want 99", bus.count_bcd);
    end
    n_checks++;
    if (wrap_cnt - w0 !== 1) begin
      n_fail++; $display("FAIL wrap_dn_pulse: got %0d cycles want 1", wrap_cnt - w0);
    end
  endtask

  task automatic test_pause();
    int w0;
    step_once(1'b0, 1'b1);       // 99 -> 98
    w0 = wrap_cnt;
    repeat (4) step_once(1'b1, 1'b0);
    n_checks++;
    if (bus.count_bcd !== dec_to_bcd(model_v)) begin
      n_fail++; $display("FAIL pause_hold: got %h want %h", bus.count_bcd, dec_to_bcd(model_v));
    end
    n_checks++;
    if (wrap_cnt - w0 !== 0) begin
      n_fail++; $display("FAIL pause_wrap: got %0d pulses want 0", wrap_cnt - w0);
    end
    step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h99) begin
      n_fail++; $display("FAIL pause_resume: got %h want 99", bus.count_bcd);
    end
  endtask

  task automatic test_dir_race();
    logic [7:0] c;
    int w0;
    do_reset();
    while (model_v != 50) step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h50) begin
      n_fail++; $display("FAIL race_setup: got %h want 50", bus.count_bcd);
    end
    w0 = wrap_cnt;
    @(negedge clk);
    bus.up_dn   = ~bus.up_dn;
    bus.tick_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (6) @(negedge clk);
    c = bus.count_bcd;
    n_checks++;
    if ((c !== 8'h49) && (c !== 8'h51)) begin
      n_fail++; $display("FAIL race_one_step: got %h want 49 or 51", c);
    end
    n_checks++;
    if (wrap_cnt - w0 !== 0) begin
      n_fail++; $display("FAIL race_wrap: got %0d pulses want 0", wrap_cnt - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    @(negedge clk);
    bus.up_dn   = 1'b1;
    bus.tick_in = 1'b1;
    @(negedge clk);              // tick sampled once, edge still in flight
    #2;
    reset_n     = 1'b0;
    bus.tick_in = 1'b0;
    #1;
    n_checks++;
    if (bus.count_bcd !== 8'h01) begin
      n_fail++; $display("FAIL reset_async: got %h want 01", bus.count_bcd);
    end
    model_v = MIN_VAL;
    w0 = wrap_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.count_bcd !== 8'h01) begin
      n_fail++; $display("FAIL reset_no_step: got %h want 01", bus.count_bcd);
    end
    n_checks++;
    if (wrap_cnt - w0 !== 0) begin
      n_fail++; $display("FAIL reset_wrap: got %0d pulses want 0", wrap_cnt - w0);
    end
    step_once(1'b1, 1'b1);
    n_checks++;
    if (bus.count_bcd !== 8'h02) begin
      n_fail++; $display("FAIL reset_next_tick: got %h want 02", bus.count_bcd);
    end
  endtask

  task automatic test_random();
    bit up;
    bit run;
    for (int i = 0; i < 60; i++) begin
      up  = 1'($urandom_range(0, 1));
      run = ($urandom_range(0, 3) != 0);
      step_once(up, run);
      n_checks++;
      if (bus.count_bcd !== dec_to_bcd(model_v)) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %h want %h", i, bus.count_bcd, dec_to_bcd(model_v));
      end
      n_checks++;
      if (bus.HEX0 !== seg_of(model_v % 10)) begin
        n_fail++; $display("FAIL rand_hex0[%0d]: got %b want %b", i, bus.HEX0, seg_of(model_v % 10));
      end
      n_checks++;
      if (bus.HEX1 !== exp_hex1(model_v)) begin
        n_fail++; $display("FAIL rand_hex1[%0d]: got %b want %b", i, bus.HEX1, exp_hex1(model_v));
      end
      n_checks++;
      if (wrap_cnt !== exp_wraps) begin
        n_fail++; $display("FAIL rand_wraps[%0d]: got %0d want %0d", i, wrap_cnt, exp_wraps);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.tick_in = 1'b0;
    bus.pause_n = 1'b1;
    bus.up_dn   = 1'b1;
    test_reset();
    test_latency();
    test_tens_carry();
    test_wrap();
    test_pause();
    test_dir_race();
    test_reset_mid();
    exp_wraps = wrap_cnt;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
